// File: rtl/inv_cipher_iter_if.sv
// Ciphertext/key in, plaintext out, valid/ready on both sides; bytes laid out [col][row].
interface inv_cipher_iter_if;
    logic [3:0][3:0][7:0] data;
    logic [3:0][3:0][7:0] key;
    logic                 i_valid;
    logic                 i_ready;
    logic [3:0][3:0][7:0] o;
    logic                 o_valid;
    logic                 o_ready;

    modport slave  (input  data, key, i_valid, o_ready, output i_ready, o, o_valid);
    modport master (output data, key, i_valid, o_ready, input  i_ready, o, o_valid);
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 decryptor, one round per clock, round keys derived on the fly.
// Latency 20 cycles (10 on key reuse); result held in DONE until o_ready, i_ready low while busy.
module inv_cipher_iter #(
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    inv_cipher_iter_if.slave   bus
);
    typedef logic [3:0][3:0][7:0] block_t;
    typedef logic [3:0][7:0]      word_t;
    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_t;

    fsm_t       fsm;
    block_t     state, rk, kstore, rk10store;
    logic [3:0] cnt;
    logic       keyOk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p, s;
        p = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1B;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic word_t subRotWord(input word_t w);
        return {sbox(w[0]), sbox(w[3]), sbox(w[2]), sbox(w[1])};
    endfunction

    function automatic block_t fwdNext(input block_t k, input logic [7:0] rc);
        block_t n;
        n[0] = k[0] ^ subRotWord(k[3]) ^ {24'h0, rc};
        n[1] = k[1] ^ n[0];
        n[2] = k[2] ^ n[1];
        n[3] = k[3] ^ n[2];
        return n;
    endfunction

    // Undo one forward expansion step: recover the previous words from the later ones.
    function automatic block_t invNext(input block_t k, input logic [7:0] rc);
        block_t p;
        p[3] = k[3] ^ k[2];
        p[2] = k[2] ^ k[1];
        p[1] = k[1] ^ k[0];
        p[0] = k[0] ^ subRotWord(p[3]) ^ {24'h0, rc};
        return p;
    endfunction

    function automatic block_t invShiftSub(input block_t s);
        block_t n;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                n[2'(c)][2'(r)] = invSbox(s[2'(c + 4 - r)][2'(r)]);
        return n;
    endfunction

    function automatic block_t invMix(input block_t s);
        block_t n;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                n[2'(c)][2'(r)] = gmul(s[2'(c)][2'(r)],     8'h0E) ^
                                  gmul(s[2'(c)][2'(r + 1)], 8'h0B) ^
                                  gmul(s[2'(c)][2'(r + 2)], 8'h0D) ^
                                  gmul(s[2'(c)][2'(r + 3)], 8'h09);
        return n;
    endfunction

    logic [7:0] rc;
    block_t     fwdRk, invRk, roundT;
    logic       keyMatch, accept;

    assign rc       = rcon(cnt);
    assign fwdRk    = fwdNext(rk, rc);
    assign invRk    = invNext(rk, rc);
    assign roundT   = invShiftSub(state) ^ invRk;
    assign keyMatch = KEY_REUSE && keyOk && (bus.key == kstore);

    assign bus.i_ready = (fsm == IDLE) || ((fsm == DONE) && bus.o_ready);
    assign accept      = bus.i_valid && bus.i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm         <= IDLE;
            state       <= '0;
            rk          <= '0;
            kstore      <= '0;
            rk10store   <= '0;
            cnt         <= '0;
            keyOk       <= 1'b0;
            bus.o       <= '0;
            bus.o_valid <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the DONE release-and-accept cycle.
            bus.o_valid <= 1'b0;
            if (keyMatch) begin
                state <= bus.data ^ rk10store;
                rk    <= rk10store;
                cnt   <= 4'd9;
                fsm   <= ROUND;
            end else begin
                state  <= bus.data;
                rk     <= bus.key;
                kstore <= bus.key;
                cnt    <= 4'd0;
                fsm    <= KEYEXP;
            end
        end else begin
            case (fsm)
                KEYEXP: begin
                    rk <= fwdRk;
                    if (cnt == 4'd9) begin
                        rk10store <= fwdRk;
                        keyOk     <= 1'b1;
                        state     <= state ^ fwdRk;
                        fsm       <= ROUND;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    if (cnt != 4'd0) begin
                        state <= invMix(roundT);
                        rk    <= invRk;
                        cnt   <= cnt - 4'd1;
                    end else begin
                        bus.o       <= roundT;
                        bus.o_valid <= 1'b1;
                        fsm         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.o_ready) begin
                        bus.o_valid <= 1'b0;
                        fsm         <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Scoreboarded bench: directed FIPS-197 vectors, backpressure, mid-run reset, random traffic.
module tb_inv_cipher_iter;
    typedef logic [15:0][7:0] bytes_t;  // index i = byte i of the block
    typedef struct { bytes_t pt; int lat; int acc; } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inv_cipher_iter_if bus ();
    inv_cipher_iter #(.KEY_REUSE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    int     cyc = 0;
    int     nChk = 0;
    int     nErr = 0;
    exp_t   expQ[$];
    logic [7:0] sbox[256];
    bit     lastKeyVld = 1'b0;
    bytes_t lastKey;
    bit     running = 1'b1;
    logic   prevVld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bytes_t hx(input logic [127:0] h);
        bytes_t r;
        for (int i = 0; i < 16; i++) r[i] = h[127 - 8 * i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] toHex(input bytes_t b);
        logic [127:0] h;
        for (int i = 0; i < 16; i++) h[127 - 8 * i -: 8] = b[i];
        return h;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    // S-box by walking generator 3 and its inverse 0xF6 in lockstep.
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic bytes_t encrypt(input bytes_t pt, input bytes_t k);
        logic [7:0] w[176];
        logic [7:0] t[4];
        logic [7:0] rcv, tmp, a0, a1, a2, a3;
        bytes_t s, n;
        for (int i = 0; i < 16; i++) w[i] = k[i];
        rcv = 8'h01;
        for (int j = 4; j < 44; j++) begin
            for (int m = 0; m < 4; m++) t[m] = w[4 * (j - 1) + m];
            if (j % 4 == 0) begin
                tmp  = t[0];
                t[0] = sbox[t[1]] ^ rcv;
                t[1] = sbox[t[2]];
                t[2] = sbox[t[3]];
                t[3] = sbox[tmp];
                rcv  = xt(rcv);
            end
            for (int m = 0; m < 4; m++) w[4 * j + m] = w[4 * (j - 4) + m] ^ t[m];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[i] ^ w[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) n[4 * c + r] = s[4 * ((c + r) % 4) + r];
            s = n;
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    n[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    n[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    n[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    n[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                s = n;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16 * rd + i];
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        nChk++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        nChk++;
        nErr++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Presents one block; returns after the accept edge, reporting cycles spent waiting.
    task automatic sendBlock(input bytes_t k, input bytes_t ct, input bytes_t pt,
                             input bit rdyAlso, output int waited);
        bit got;
        int lat;
        got = 1'b0;
        waited = 0;
        @(posedge clk); #1;
        bus.key = k;
        bus.data = ct;
        bus.i_valid = 1'b1;
        if (rdyAlso) bus.o_ready = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (bus.i_ready) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            flag("accept_timeout");
            bus.i_valid = 1'b0;
        end else begin
            lat = (lastKeyVld && lastKey == k) ? 10 : 20;
            lastKey = k;
            lastKeyVld = 1'b1;
            expQ.push_back('{pt: pt, lat: lat, acc: cyc + 1});
            @(posedge clk); #1;
            bus.i_valid = 1'b0;
            bus.data = {$urandom, $urandom, $urandom, $urandom};
            bus.key = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic waitDrain();
        bit empty;
        empty = 1'b0;
        for (int n = 0; n < 600 && !empty; n++) begin
            @(negedge clk); #1;
            if (expQ.size() == 0) empty = 1'b1;
        end
        if (!empty) flag("drain_timeout");
    endtask

    // Monitor: latency at each o_valid rise, plaintext at each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1 && prevVld !== 1'b1) begin
                if (expQ.size() == 0) flag("spurious_valid");
                else check("latency", cyc - expQ[0].acc, expQ[0].lat);
            end
            if (bus.o_valid === 1'b1 && bus.o_ready === 1'b1) begin
                if (expQ.size() == 0) flag("unexpected_output");
                else begin
                    e = expQ.pop_front();
                    check("plaintext", toHex(bus.o), toHex(e.pt));
                end
            end
            prevVld = bus.o_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t kC1, cC1, pC1, kAB, cAB, pAB, pool[3], k, pt;
        int w;
        buildSbox();
        kC1 = hx(128'h000102030405060708090a0b0c0d0e0f);
        cC1 = hx(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        pC1 = hx(128'h00112233445566778899aabbccddeeff);
        kAB = hx(128'h2b7e151628aed2a6abf7158809cf4f3c);
        cAB = hx(128'h3925841d02dc09fbdc118597196a0b32);
        pAB = hx(128'h3243f6a8885a308d313198a2e0370734);

        rst = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        bus.data = '0;
        bus.key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o", bus.o, 128'h0);
        check("reset_o_valid", bus.o_valid, 0);
        check("reset_i_ready", bus.i_ready, 1);
        @(negedge clk) rst = 1'b1;

        // FIPS-197 C.1 with expansion; i_ready stays low while busy, o_valid lasts one cycle.
        bus.o_ready = 1'b1;
        sendBlock(kC1, cC1, pC1, 1'b1, w);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            check("busy_i_ready", bus.i_ready, 0);
        end
        waitDrain();
        @(negedge clk);
        check("valid_one_cycle", bus.o_valid, 0);

        // Same key: expansion skipped.
        sendBlock(kC1, cC1, pC1, 1'b1, w);
        waitDrain();

        // FIPS-197 Appendix B, key change.
        sendBlock(kAB, cAB, pAB, 1'b1, w);
        waitDrain();

        // Backpressure, then release and accept on the same edge.
        @(posedge clk); #1 bus.o_ready = 1'b0;
        sendBlock(kC1, cC1, pC1, 1'b0, w);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
                @(negedge clk);
                if (bus.o_valid) seen = 1'b1;
            end
            if (!seen) flag("bp_valid_timeout");
        end
        repeat (7) begin
            @(negedge clk);
            check("bp_hold_o", toHex(bus.o), toHex(pC1));
            check("bp_hold_valid", bus.o_valid, 1);
            check("bp_i_ready", bus.i_ready, 0);
        end
        sendBlock(kC1, cC1, pC1, 1'b1, w);
        check("simul_accept_wait", w, 0);
        @(negedge clk);
        check("release_drop", bus.o_valid, 0);
        waitDrain();

        // Reset deep inside key expansion discards the block and the stored key.
        sendBlock(kAB, cAB, pAB, 1'b1, w);
        repeat (7) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_o_valid", bus.o_valid, 0);
        check("midrst_o", bus.o, 128'h0);
        check("midrst_idle", bus.i_ready, 1);
        expQ.delete();
        lastKeyVld = 1'b0;
        @(negedge clk) rst = 1'b1;
        sendBlock(kAB, cAB, pAB, 1'b1, w);
        waitDrain();

        // Random traffic over a small key pool so reuse and key changes both occur.
        for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    k = pool[$urandom_range(0, 2)];
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    sendBlock(k, encrypt(pt, k), pt, 1'b0, w);
                end
                waitDrain();
                running = 1'b0;
            end
            begin
                while (running) begin
                    @(posedge clk); #1;
                    bus.o_ready = ($urandom_range(0, 9) < 7);
                end
                bus.o_ready = 1'b1;
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
        $finish;
    end
endmodule

// File: doc/inv_cipher_iter.md
Name: inv_cipher_iter

Overview:
- Iterative AES-128 inverse cipher (decryption) core.
- Counterpart to the unrolled combinational forward cipher; consumes its ciphertext and returns the plaintext.
- Processes one round per clock and derives round keys on the fly; there is no 44-word key schedule.
- Sits between the ciphertext source and the plaintext sink, with a valid/ready handshake on both sides.

Parameters:
- KEY_REUSE, 1, when 1 the core skips key expansion if the new key equals the previously expanded key.

Ports:
- clk  in  1  sole clock.
- rst  in  1  Asynchronous, active-low reset.
- data  in  8 x [4][4]  ciphertext block; data[c][r] = byte 4c+r of the 128-bit block, byte 0 first.
- key  in  8 x [4][4]  cipher key, same layout as data.
- i_valid  in  1  data/key valid.
- i_ready  out  1  core accepts a block.
- o  out  8 x [4][4]  plaintext, same layout.
- o_valid  out  1  o valid.
- o_ready  in  1  sink accepts o.

Behaviour:
- One clock; reset is asynchronous and active-low. Reset asserted: FSM=IDLE, o=all zeros, o_valid=0, rk=0, state=0, cnt=0, key_ok=0. Reset takes effect immediately, including mid-operation; any in-flight block is discarded.
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- i_ready = (FSM==IDLE) | (FSM==DONE & o_ready). Combinational from the FSM state and o_ready.
- Accept occurs when i_valid & i_ready. On accept:
  - state <= data; cnt <= 0.
  - If KEY_REUSE=1 & key_ok & key==kstore: rk <= rk10store and go to ROUND.
  - Otherwise: rk <= key, kstore <= key, and go to KEYEXP.
- KEYEXP (10 cycles, cnt 0..9):
  - rk <= fwd_next(rk, RCON[cnt]), using standard SubWord/RotWord with RCON = 01,02,04,08,10,20,40,80,1B,36.
  - On cnt==9: rk10store <= next rk; key_ok <= 1; state <= state ^ next rk; cnt <= 9; go to ROUND.
- Skip path: on entering ROUND directly, the initial AddRoundKey is still required. On accept, state <= data ^ rk10store and cnt <= 9.
- ROUND (10 cycles, cnt 9 down to 0):
  - k = inv_next(rk, RCON[cnt]) = round key cnt. Inverse schedule: w[i-4] = w[i] ^ w[i-1] for words 3..1; word 0 = w4 ^ SubWord(RotWord(w3_prev)) ^ RCON.
  - t = InvSubBytes(InvShiftRows(state)) ^ k.
  - cnt != 0: state <= InvMixColumns(t); rk <= k; cnt--.
  - cnt == 0: o <= t; o_valid <= 1; go to DONE.
- Arithmetic is in GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are 0e,0b,0d,09. Byte ops are 8-bit; there is no overflow.
- DONE: o and o_valid hold until o_ready.
  - o_ready & ~i_valid: o_valid <= 0 and go to IDLE.
  - o_ready & i_valid (simultaneous release and accept): the new block is accepted the same cycle; o_valid <= 0; go to KEYEXP or ROUND per the key rule.
  - o retains its last value after o_valid falls.
- Latency (accept edge to o_valid rising edge): 20 cycles with expansion, 10 cycles on key reuse. Throughput is one block per 21 cycles, or 11 on reuse, when the sink is always ready.
- i_valid/data/key are ignored outside accept cycles. Inputs need not be held after accept.
- KEY_REUSE=0: always KEYEXP; key_ok is never used.
- No X on outputs after reset. The key compare is full 128-bit.

Test Plan:
- FIPS-197 C.1, first block: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a, o_ready=1 -> o=00112233445566778899aabbccddeeff. o_valid rises exactly 20 cycles after accept, high for 1 cycle. i_ready is low during processing.
- Key reuse: same key again, data 69c4e0d86a7b0430d8cdb78070b4c55a -> same plaintext after 10 cycles. With KEY_REUSE=0 the latency is 20 cycles.
- FIPS-197 A/B key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 -> o=3243f6a8885a308d313198a2e0370734. This is a key change, so the latency is 20 cycles.
- Backpressure: o_ready=0 for 7 cycles after o_valid -> o and o_valid stable and i_ready=0. Then o_ready=1 with i_valid=1 -> the next block is accepted the same cycle and o_valid drops the next cycle.
- Reset mid-operation: assert rst low at cycle 8 of KEYEXP -> o_valid=0 and o=0 immediately, FSM=IDLE. Then decrypt the same key -> full 20-cycle latency (key_ok was cleared) and correct plaintext.
- Random: 200 random key/plaintext pairs encrypted by the forward cipher model, random i_valid/o_ready gaps -> every o matches the original plaintext, in order, none lost or duplicated.
